// File: rtl/ula_operandos.sv
// Operand sequencer for the 8-bit ULA: loads A, B and op code on successive button presses, then latches S/FLAG_O.
// One EXECUTA cycle after the B press; result registered at the edge ending EXECUTA. There is no backpressure; presses are ignored in EXECUTA.
module ula_operandos #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] dado,
    input  logic [1:0]   op,
    input  logic         botao,
    input  logic [N-1:0] S,
    input  logic         FLAG_O,
    output logic [N-1:0] A,
    output logic [N-1:0] B,
    output logic [1:0]   vetor,
    output logic         valido,
    output logic [N-1:0] resultado,
    output logic         overflow,
    output logic [3:0]   ovf_cont,
    output logic [1:0]   estado
);

    localparam logic [1:0] CARREGA_A = 2'b00;
    localparam logic [1:0] CARREGA_B = 2'b01;
    localparam logic [1:0] EXECUTA   = 2'b10;
    localparam logic [1:0] MOSTRA    = 2'b11;

    logic [1:0]   r_estado;
    logic         r_botao_ant;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [1:0]   r_vetor;
    logic [N-1:0] r_resultado;
    logic         r_overflow;
    logic [3:0]   r_ovf_cont;
    logic         w_press;

    assign w_press = botao & ~r_botao_ant;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Preset high so a button held across reset release is not seen as a press
            r_botao_ant <= 1'b1;
            r_estado    <= CARREGA_A;
            r_a         <= '0;
            r_b         <= '0;
            r_vetor     <= '0;
            r_resultado <= '0;
            r_overflow  <= 1'b0;
            r_ovf_cont  <= '0;
        end else begin
            r_botao_ant <= botao;
            case (r_estado)
                CARREGA_A: begin
                    if (w_press) begin
                        r_a      <= dado;
                        r_estado <= CARREGA_B;
                    end
                end
                CARREGA_B: begin
                    if (w_press) begin
                        r_b      <= dado;
                        r_vetor  <= op;
                        r_estado <= EXECUTA;
                    end
                end
                EXECUTA: begin
                    r_resultado <= S;
                    r_overflow  <= FLAG_O;
                    if (FLAG_O && (r_ovf_cont != 4'hF))
                        r_ovf_cont <= r_ovf_cont + 4'd1;
                    r_estado <= MOSTRA;
                end
                default: begin
                    if (w_press)
                        r_estado <= CARREGA_A;
                end
            endcase
        end
    end

    assign A         = r_a;
    assign B         = r_b;
    assign vetor     = r_vetor;
    assign valido    = (r_estado == EXECUTA);
    assign resultado = r_resultado;
    assign overflow  = r_overflow;
    assign ovf_cont  = r_ovf_cont;
    assign estado    = r_estado;

endmodule

// File: tb/tb_ula_operandos.sv
// Directed bench for ula_operandos with a behavioural 8-bit ULA closing the loop on A/B/vetor -> S/FLAG_O.
module tb_ula_operandos;

    logic       clk;
    logic       reset;
    logic [7:0] dado;
    logic [1:0] op;
    logic       botao;
    logic [7:0] S;
    logic       FLAG_O;
    logic [7:0] A;
    logic [7:0] B;
    logic [1:0] vetor;
    logic       valido;
    logic [7:0] resultado;
    logic       overflow;
    logic [3:0] ovf_cont;
    logic [1:0] estado;

    int n_assert = 0;
    int n_fail   = 0;

    ula_operandos #(.N(8)) dut (
        .clk(clk), .reset(reset), .dado(dado), .op(op), .botao(botao),
        .S(S), .FLAG_O(FLAG_O), .A(A), .B(B), .vetor(vetor), .valido(valido),
        .resultado(resultado), .overflow(overflow), .ovf_cont(ovf_cont), .estado(estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ULA: two's complement add/sub with signed overflow detection
    always_comb begin
        S      = 8'h00;
        FLAG_O = 1'b0;
        case (vetor)
            2'b00: S = A & B;
            2'b01: S = A | B;
            2'b10: begin
                S      = A + B;
                FLAG_O = (A[7] == B[7]) && (S[7] != A[7]);
            end
            default: begin
                S      = A - B;
                FLAG_O = (A[7] != B[7]) && (S[7] != A[7]);
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [7:0] d, input logic [1:0] o);
        @(negedge clk);
        dado  = d;
        op    = o;
        botao = 1'b1;
        @(negedge clk);
        botao = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        botao = 1'b1;
        dado  = 8'h00;
        op    = 2'b00;

        // Reset with button held, then keep it held after release
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_estado", estado, 2'b00);
        chk("rst_A", A, 8'h00);
        chk("rst_B", B, 8'h00);
        chk("rst_vetor", vetor, 2'b00);
        chk("rst_valido", valido, 1'b0);
        chk("rst_resultado", resultado, 8'h00);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_ovf_cont", ovf_cont, 4'h0);
        botao = 1'b0;
        @(negedge clk);

        // Held button in CARREGA_A: exactly one advance
        dado  = 8'd100;
        botao = 1'b1;
        repeat (10) @(negedge clk);
        chk("hold_estado", estado, 2'b01);
        chk("hold_A", A, 8'd100);
        botao = 1'b0;
        @(negedge clk);

        // 100 + 50 overflows
        press(8'd50, 2'b10);
        chk("add_valido", valido, 1'b1);
        chk("add_estado_ex", estado, 2'b10);
        chk("add_B", B, 8'd50);
        chk("add_vetor", vetor, 2'b10);
        @(negedge clk);
        chk("add_valido_off", valido, 1'b0);
        chk("add_estado", estado, 2'b11);
        chk("add_res", resultado, 8'h96);
        chk("add_ovf", overflow, 1'b1);
        chk("add_cnt", ovf_cont, 4'd1);

        // 5 - 3, button held from the B press through EXECUTA into MOSTRA
        press(8'd0, 2'b00);
        chk("mostra_to_a", estado, 2'b00);
        press(8'd5, 2'b00);
        @(negedge clk);
        dado  = 8'd3;
        op    = 2'b11;
        botao = 1'b1;
        @(negedge clk);
        chk("sub_valido", valido, 1'b1);
        @(negedge clk);
        chk("sub_estado", estado, 2'b11);
        chk("sub_res", resultado, 8'd2);
        chk("sub_ovf", overflow, 1'b0);
        chk("sub_cnt", ovf_cont, 4'd1);
        repeat (3) @(negedge clk);
        chk("held_mostra", estado, 2'b11);
        botao = 1'b0;
        @(negedge clk);
        chk("released_mostra", estado, 2'b11);
        press(8'd0, 2'b00);
        chk("distinct_press", estado, 2'b00);

        // -128 - 1 overflows
        press(8'h80, 2'b00);
        press(8'd1, 2'b11);
        @(negedge clk);
        chk("sub2_res", resultado, 8'h7F);
        chk("sub2_ovf", overflow, 1'b1);
        chk("sub2_cnt", ovf_cont, 4'd2);

        // Reset in CARREGA_B after A=7
        press(8'd0, 2'b00);
        press(8'd7, 2'b00);
        chk("mid_estado_b", estado, 2'b01);
        chk("mid_A7", A, 8'd7);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_estado", estado, 2'b00);
        chk("mid_rst_A", A, 8'h00);
        chk("mid_rst_cnt", ovf_cont, 4'h0);
        reset = 1'b0;
        @(negedge clk);

        // Reset in MOSTRA after 127 + 1
        press(8'd127, 2'b00);
        press(8'd1, 2'b10);
        @(negedge clk);
        chk("pre_rst_res", resultado, 8'h80);
        chk("pre_rst_cnt", ovf_cont, 4'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_estado", estado, 2'b00);
        chk("mrst_res", resultado, 8'h00);
        chk("mrst_ovf", overflow, 1'b0);
        chk("mrst_cnt", ovf_cont, 4'h0);
        reset = 1'b0;
        @(negedge clk);

        // 17 overflowing additions: counter saturates at 15
        for (int i = 1; i <= 17; i++) begin
            press(8'd127, 2'b00);
            press(8'd1, 2'b10);
            @(negedge clk);
            chk("sat_res", resultado, 8'h80);
            chk("sat_ovf", overflow, 1'b1);
            chk("sat_cnt", ovf_cont, (i > 15) ? 32'd15 : 32'(i));
            press(8'd0, 2'b00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
